gpio_trace_capture: RTL and testbench

//  Hardware change-capture for the SoC GPIO ports. Watches NUM_PORTS ports (out + dir) and, on any change,

---
 rtl/gpio_trace_capture.sv | 194 +++++++++++++++++++
 tb/tb_gpio_trace_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_trace_capture.sv
// gpio_trace_capture: timestamped change capture of NUM_PORTS GPIO ports into a show-ahead event FIFO.
// Latency: a change sampled at edge N is pending at N, pushed at N+1 and visible on evt_* after N+1.
// Backpressure: evt_valid/evt_ready; when full, pending events wait and only coalesced changes set overflow.
// Build option GPIO_TRACE_DIR_EN: pin_dir is also watched and stored; otherwise evt_dir is tied to 0.
module gpio_trace_capture #(
   parameter int NUM_PORTS = 3,
   parameter int PORT_W    = 8,
   parameter int DEPTH     = 16,
   parameter int TS_W      = 24,
   localparam int PIDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        clear,
   input  logic [NUM_PORTS*PORT_W-1:0] pin_out,
   input  logic [NUM_PORTS*PORT_W-1:0] pin_dir,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [PIDX_W-1:0]           evt_port,
   output logic [PORT_W-1:0]           evt_data,
   output logic [PORT_W-1:0]           evt_dir,
   output logic [TS_W-1:0]             evt_ts,
   output logic                        overflow,
   output logic [CNT_W-1:0]            count
);

   localparam int AW = $clog2(DEPTH);

   logic [TS_W-1:0]      ts;
   logic [PORT_W-1:0]    base_out [NUM_PORTS];
   logic [PORT_W-1:0]    snap_out [NUM_PORTS];
   logic [TS_W-1:0]      snap_ts  [NUM_PORTS];
   logic [NUM_PORTS-1:0] pending;
   logic [NUM_PORTS-1:0] changed;
   logic [NUM_PORTS-1:0] grant;
   logic [PIDX_W-1:0]    push_sel;
   logic                 push_any;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [PIDX_W-1:0]    mem_port [DEPTH];
   logic [PORT_W-1:0]    mem_out  [DEPTH];
   logic [TS_W-1:0]      mem_ts   [DEPTH];
`ifdef GPIO_TRACE_DIR_EN
   logic [PORT_W-1:0]    base_dir [NUM_PORTS];
   logic [PORT_W-1:0]    snap_dir [NUM_PORTS];
   logic [PORT_W-1:0]    mem_dir  [DEPTH];
`else
   logic                 unused_dir;
   assign unused_dir = ^pin_dir;
`endif

   // Per-port change detect against the baseline; suppressed while disabled or clearing.
   always_comb begin
      changed = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (enable && !clear) begin
            changed[p] = (pin_out[p*PORT_W +: PORT_W] != base_out[p]);
`ifdef GPIO_TRACE_DIR_EN
            if (pin_dir[p*PORT_W +: PORT_W] != base_dir[p]) changed[p] = 1'b1;
`endif
         end
      end
   end

   // Fixed-priority arbiter: lowest-index pending port wins the single push slot.
   always_comb begin
      push_sel = '0;
      push_any = 1'b0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
         if (pending[p]) begin
            push_sel = PIDX_W'(p);
            push_any = 1'b1;
         end
      end
   end

   assign evt_valid = (count != '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign pop       = evt_valid && evt_ready;
   // A pop in the same clock frees the slot, so a full FIFO can still accept.
   assign push      = push_any && (!full || pop);

   // One-hot view of which port is pushed this clock.
   always_comb begin
      grant = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         grant[p] = push && (push_sel == PIDX_W'(p));
      end
   end

   // Baseline follows the inputs every clock: while disabled, on clear, and after a capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            base_out[p] <= '0;
`ifdef GPIO_TRACE_DIR_EN
            base_dir[p] <= '0;
`endif
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            base_out[p] <= pin_out[p*PORT_W +: PORT_W];
`ifdef GPIO_TRACE_DIR_EN
            base_dir[p] <= pin_dir[p*PORT_W +: PORT_W];
`endif
         end
      end
   end

   // Snapshot/pending per port; a change on a still-waiting port overwrites it and is flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         overflow <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            snap_out[p] <= '0;
            snap_ts[p]  <= '0;
`ifdef GPIO_TRACE_DIR_EN
            snap_dir[p] <= '0;
`endif
         end
      end else if (clear) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (changed[p]) begin
               snap_out[p] <= pin_out[p*PORT_W +: PORT_W];
               snap_ts[p]  <= ts;
`ifdef GPIO_TRACE_DIR_EN
               snap_dir[p] <= pin_dir[p*PORT_W +: PORT_W];
`endif
               pending[p]  <= 1'b1;
               // Changing again while being pushed is a fresh event, not a loss.
               if (pending[p] && !grant[p]) overflow <= 1'b1;
            end else if (grant[p]) begin
               pending[p] <= 1'b0;
            end
         end
      end
   end

   // Free-running timestamp while enabled; wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ts <= '0;
      else if (clear)  ts <= '0;
      else if (enable) ts <= ts + TS_W'(1);
   end

   // FIFO storage write; contents need no reset since outputs are gated by evt_valid.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_port[wr_ptr] <= push_sel;
         mem_out[wr_ptr]  <= snap_out[push_sel];
         mem_ts[wr_ptr]   <= snap_ts[push_sel];
`ifdef GPIO_TRACE_DIR_EN
         mem_dir[wr_ptr]  <= snap_dir[push_sel];
`endif
      end
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   assign evt_port = evt_valid ? mem_port[rd_ptr] : '0;
   assign evt_data = evt_valid ? mem_out[rd_ptr]  : '0;
   assign evt_ts   = evt_valid ? mem_ts[rd_ptr]   : '0;
`ifdef GPIO_TRACE_DIR_EN
   assign evt_dir  = evt_valid ? mem_dir[rd_ptr]  : '0;
`else
   assign evt_dir  = '0;
`endif

endmodule

// File: tb/tb_gpio_trace_capture.sv
// Bench for gpio_trace_capture: directed vector table plus multi-cycle corner sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Build with GPIO_TRACE_DIR_EN defined to exercise the direction-capture variant.
module tb_gpio_trace_capture;
   localparam int NP = 3;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          clear;
   logic          evt_ready;
   logic [NP*PW-1:0] pin_out;
   logic [NP*PW-1:0] pin_dir;
   logic          evt_valid;
   logic [1:0]    evt_port;
   logic [7:0]    evt_data;
   logic [7:0]    evt_dir;
   logic [23:0]   evt_ts;
   logic          overflow;
   logic [4:0]    count;

   int checks = 0;
   int errors = 0;
   logic [7:0]  cur_out [NP];
   logic [7:0]  cur_dir [NP];
   logic [23:0] m_ts;
   logic [23:0] exp_ts;
   logic [7:0]  t3_val [17];
   logic [23:0] t3_ts  [17];

   typedef struct {
      int         port;
      logic [7:0] out;
      logic [7:0] dir;
      logic       exp_evt;
      logic [7:0] exp_dir;
   } vec_t;
   vec_t vt [6];

   gpio_trace_capture dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .pin_out(pin_out), .pin_dir(pin_dir),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_port(evt_port),
      .evt_data(evt_data), .evt_dir(evt_dir), .evt_ts(evt_ts),
      .overflow(overflow), .count(count)
   );

   always #5 clk = ~clk;

   // Reference timestamp: counts enabled edges, zeroed by reset and clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      m_ts <= '0;
      else if (clear)  m_ts <= '0;
      else if (enable) m_ts <= m_ts + 24'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         pin_out[p*PW +: PW] = cur_out[p];
         pin_dir[p*PW +: PW] = cur_dir[p];
      end
   endtask

   function automatic logic [7:0] dmask(input logic [7:0] d);
`ifdef GPIO_TRACE_DIR_EN
      return d;
`else
      return 8'h00;
`endif
   endfunction

   // Check the head record, then accept it with a one-clock ready pulse.
   task automatic pop_check(input string name, input int port, input logic [7:0] data,
                            input logic [7:0] dir, input logic [23:0] tsv);
      chk({name, " valid"}, {31'd0, evt_valid}, 32'd1);
      chk({name, " port"}, {30'd0, evt_port}, port);
      chk({name, " data"}, {24'd0, evt_data}, {24'd0, data});
      chk({name, " dir"}, {24'd0, evt_dir}, {24'd0, dmask(dir)});
      chk({name, " ts"}, {8'd0, evt_ts}, {8'd0, tsv});
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
   endtask

   initial begin
      vt[0] = '{1, 8'h55, 8'h00, 1'b1, 8'h00};
      vt[2] = '{0, 8'h11, 8'h00, 1'b0, 8'h00};
      vt[4] = '{2, 8'hC3, 8'hFF, 1'b1, dmask(8'hFF)};
`ifdef GPIO_TRACE_DIR_EN
      vt[1] = '{2, 8'h33, 8'hFF, 1'b1, 8'hFF};
      vt[3] = '{1, 8'h5A, 8'h0F, 1'b1, 8'h0F};
      vt[5] = '{0, 8'h11, 8'h80, 1'b1, 8'h80};
`else
      vt[1] = '{2, 8'h33, 8'hFF, 1'b0, 8'h00};
      vt[3] = '{1, 8'h5A, 8'h0F, 1'b1, 8'h00};
      vt[5] = '{0, 8'h11, 8'h80, 1'b0, 8'h00};
`endif

      rst_n = 1'b0; enable = 1'b1; clear = 1'b0; evt_ready = 1'b0;
      for (int p = 0; p < NP; p++) begin cur_out[p] = 8'h00; cur_dir[p] = 8'h00; end
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("reset valid", {31'd0, evt_valid}, 32'd0);
      chk("reset count", {27'd0, count}, 32'd0);
      chk("reset overflow", {31'd0, overflow}, 32'd0);
      chk("reset data", {24'd0, evt_data}, 32'd0);
      chk("reset ts", {8'd0, evt_ts}, 32'd0);
      rst_n = 1'b1;

      // First event: ten enabled edges, change sampled at the eleventh carries ts=10.
      repeat (10) step();
      cur_out[0] = 8'h01; drive();
      step();
      chk("t1 latency", {31'd0, evt_valid}, 32'd0);
      step();
      chk("t1 count", {27'd0, count}, 32'd1);
      pop_check("t1", 0, 8'h01, 8'h00, 24'd10);
      chk("t1 drained", {27'd0, count}, 32'd0);

      // Simultaneous change on all ports: drained in index order with one timestamp.
      cur_out[0] = 8'h11; cur_out[1] = 8'h22; cur_out[2] = 8'h33; drive();
      exp_ts = m_ts;
      repeat (4) step();
      chk("t2 count", {27'd0, count}, 32'd3);
      pop_check("t2 p0", 0, 8'h11, 8'h00, exp_ts);
      pop_check("t2 p1", 1, 8'h22, 8'h00, exp_ts);
      pop_check("t2 p2", 2, 8'h33, 8'h00, exp_ts);
      chk("t2 overflow", {31'd0, overflow}, 32'd0);

      // Table of single-port changes, including dir-only and no-change cases.
      for (int i = 0; i < 6; i++) begin
         cur_out[vt[i].port] = vt[i].out;
         cur_dir[vt[i].port] = vt[i].dir;
         drive();
         exp_ts = m_ts;
         step(); step();
         chk($sformatf("vec%0d valid", i), {31'd0, evt_valid}, {31'd0, vt[i].exp_evt});
         if (vt[i].exp_evt)
            pop_check($sformatf("vec%0d", i), vt[i].port, vt[i].out, vt[i].exp_dir, exp_ts);
         else
            chk($sformatf("vec%0d idle dir", i), {24'd0, evt_dir}, 32'd0);
         chk($sformatf("vec%0d count", i), {27'd0, count}, 32'd0);
      end

      // Fill to full with one change held pending, then coalesce one more.
      for (int i = 0; i < 17; i++) begin
         cur_out[0] = 8'h40 + 8'(i); drive();
         t3_val[i] = cur_out[0]; t3_ts[i] = m_ts;
         step(); step();
      end
      chk("t3 full count", {27'd0, count}, 32'd16);
      chk("t3 no overflow", {31'd0, overflow}, 32'd0);
      cur_out[0] = 8'hEE; drive();
      t3_val[16] = 8'hEE; t3_ts[16] = m_ts;
      step(); step();
      chk("t3 overflow", {31'd0, overflow}, 32'd1);
      chk("t3 count held", {27'd0, count}, 32'd16);
      evt_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("t3 ev%0d data", i), {24'd0, evt_data}, {24'd0, t3_val[i]});
         chk($sformatf("t3 ev%0d ts", i), {8'd0, evt_ts}, {8'd0, t3_ts[i]});
         chk($sformatf("t3 ev%0d dir", i), {24'd0, evt_dir}, {24'd0, dmask(cur_dir[0])});
         step();
         if (i == 0) chk("t4 push+pop full", {27'd0, count}, 32'd16);
      end
      evt_ready = 1'b0;
      chk("t3 drained valid", {31'd0, evt_valid}, 32'd0);
      chk("t3 drained count", {27'd0, count}, 32'd0);

      // Disabled window: baseline tracks, no event on re-enable, ts frozen.
      enable = 1'b0;
      cur_out[1] = 8'hA5; drive();
      repeat (3) step();
      enable = 1'b1;
      repeat (3) step();
      chk("t5 no event", {31'd0, evt_valid}, 32'd0);
      cur_out[2] = 8'h77; drive();
      exp_ts = m_ts;
      step(); step();
      pop_check("t5 ts frozen", 2, 8'h77, cur_dir[2], exp_ts);

      // Build up queued events and an overflow, then clear together with an input change.
      cur_out[0] = 8'h01; cur_out[1] = 8'h02; drive();
      step();
      cur_out[1] = 8'h03; drive();
      step(); step();
      chk("t5 pre-clear overflow", {31'd0, overflow}, 32'd1);
      chk("t5 pre-clear count", {27'd0, count}, 32'd2);
      clear = 1'b1; cur_out[2] = 8'h99; drive();
      step();
      clear = 1'b0;
      chk("t5 clear count", {27'd0, count}, 32'd0);
      chk("t5 clear overflow", {31'd0, overflow}, 32'd0);
      chk("t5 clear valid", {31'd0, evt_valid}, 32'd0);
      cur_out[0] = 8'h5C; drive();
      step(); step();
      chk("t5 post-clear count", {27'd0, count}, 32'd1);
      pop_check("t5 ts zero", 0, 8'h5C, cur_dir[0], 24'd0);

      // Asynchronous reset with an event queued discards it immediately.
      cur_out[1] = 8'h6B; drive();
      step(); step();
      chk("t7 queued", {27'd0, count}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7 async valid", {31'd0, evt_valid}, 32'd0);
      chk("t7 async count", {27'd0, count}, 32'd0);
      chk("t7 async data", {24'd0, evt_data}, 32'd0);
      #3 rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
